// File: rtl/axi4_lite_reg_bank_if.sv
// axi4_lite_if: AXI4-Lite bundle shared by a master and a slave.
// Ports: none; signals grouped into slv_port (slave side) and mst_port (master side) modports.
interface axi4_lite_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport slv_port (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport mst_port (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi4_lite_reg_bank.sv
// axi4_lite_reg_bank: AXI4-Lite slave with NUM_REGS RW/RO registers and per-register access pulses.
// Ports: i_clk, i_async_rst_n (async, active-low), if_s_axi4_lite (AXI4-Lite slave),
//        o_regs (flattened RW values, RO slots 0), i_ro_vals (RO read values),
//        o_wr_pulse / o_rd_pulse (one-cycle per-register access strobes).
module axi4_lite_reg_bank #(
    parameter int AXI4_LITE_ADDR_BIT_WIDTH = 32,
    parameter int AXI4_LITE_DATA_BIT_WIDTH = 32,
    parameter int NUM_REGS = 8,
    parameter logic [NUM_REGS-1:0] RO_MASK = '0,
    parameter logic [NUM_REGS*AXI4_LITE_DATA_BIT_WIDTH-1:0] RST_VALS = '0
) (
    input  logic                                         i_clk,
    input  logic                                         i_async_rst_n,
    axi4_lite_if.slv_port                                if_s_axi4_lite,
    output logic [NUM_REGS*AXI4_LITE_DATA_BIT_WIDTH-1:0] o_regs,
    input  logic [NUM_REGS*AXI4_LITE_DATA_BIT_WIDTH-1:0] i_ro_vals,
    output logic [NUM_REGS-1:0]                          o_wr_pulse,
    output logic [NUM_REGS-1:0]                          o_rd_pulse
);
    localparam int AW  = AXI4_LITE_ADDR_BIT_WIDTH;
    localparam int DW  = AXI4_LITE_DATA_BIT_WIDTH;
    localparam int OFF = $clog2(DW / 8);
    localparam int IW  = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;

    logic            rdy_q, rdy_d;
    logic            aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic [AW-1:0]   awaddr_q, awaddr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [DW/8-1:0] wstrb_q, wstrb_d;
    logic            bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    logic [1:0]      bresp_q, bresp_d, rresp_q, rresp_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic [DW-1:0]   regs_q [NUM_REGS];
    logic [DW-1:0]   regs_d [NUM_REGS];
    logic [DW-1:0]   ro_arr [NUM_REGS];
    logic [NUM_REGS-1:0] wr_pulse_q, wr_pulse_d, rd_pulse_q, rd_pulse_d;

    logic            aw_hs, w_hs, ar_hs, commit, w_in, w_ok, r_in;
    logic [AW-1:0]   w_addr, w_idx, r_idx;
    logic [DW-1:0]   w_data;
    logic [DW/8-1:0] w_strb;
    logic [IW-1:0]   w_slot, r_slot;

    // rdy_q keeps every ready low until the first edge after reset release
    assign if_s_axi4_lite.awready = rdy_q & ~aw_held_q & ~bvalid_q;
    assign if_s_axi4_lite.wready  = rdy_q & ~w_held_q & ~bvalid_q;
    assign if_s_axi4_lite.arready = rdy_q & ~rvalid_q;
    assign if_s_axi4_lite.bvalid  = bvalid_q;
    assign if_s_axi4_lite.bresp   = bresp_q;
    assign if_s_axi4_lite.rvalid  = rvalid_q;
    assign if_s_axi4_lite.rresp   = rresp_q;
    assign if_s_axi4_lite.rdata   = rdata_q;
    assign o_wr_pulse = wr_pulse_q;
    assign o_rd_pulse = rd_pulse_q;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_slot
        assign o_regs[g*DW +: DW] = regs_q[g];
        assign ro_arr[g] = i_ro_vals[g*DW +: DW];
    end

    assign aw_hs  = if_s_axi4_lite.awvalid & if_s_axi4_lite.awready;
    assign w_hs   = if_s_axi4_lite.wvalid & if_s_axi4_lite.wready;
    assign ar_hs  = if_s_axi4_lite.arvalid & if_s_axi4_lite.arready;
    // the second of the AW/W halves (or both together) completes the write
    assign commit = (aw_hs | aw_held_q) & (w_hs | w_held_q);
    assign w_addr = aw_held_q ? awaddr_q : if_s_axi4_lite.awaddr;
    assign w_data = w_held_q ? wdata_q : if_s_axi4_lite.wdata;
    assign w_strb = w_held_q ? wstrb_q : if_s_axi4_lite.wstrb;
    assign w_idx  = w_addr >> OFF;
    assign r_idx  = if_s_axi4_lite.araddr >> OFF;
    assign w_slot = w_idx[IW-1:0];
    assign r_slot = r_idx[IW-1:0];
    assign w_in   = w_idx < AW'(NUM_REGS);
    assign r_in   = r_idx < AW'(NUM_REGS);
    assign w_ok   = w_in && !RO_MASK[w_slot];

    always_comb begin
        rdy_d      = 1'b1;
        aw_held_d  = aw_held_q;
        awaddr_d   = awaddr_q;
        w_held_d   = w_held_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bvalid_d   = bvalid_q & ~if_s_axi4_lite.bready;
        bresp_d    = bresp_q;
        regs_d     = regs_q;
        wr_pulse_d = '0;
        if (aw_hs && !commit) begin
            aw_held_d = 1'b1;
            awaddr_d  = if_s_axi4_lite.awaddr;
        end
        if (w_hs && !commit) begin
            w_held_d = 1'b1;
            wdata_d  = if_s_axi4_lite.wdata;
            wstrb_d  = if_s_axi4_lite.wstrb;
        end
        if (commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = w_ok ? 2'b00 : 2'b10;
            if (w_ok) begin
                wr_pulse_d[w_slot] = 1'b1;
                for (int b = 0; b < DW / 8; b++)
                    if (w_strb[b]) regs_d[w_slot][b*8 +: 8] = w_data[b*8 +: 8];
            end
        end
    end

    // reads sample regs_q, so a same-cycle write commit is not visible yet
    always_comb begin
        rvalid_d   = rvalid_q & ~if_s_axi4_lite.rready;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        rd_pulse_d = '0;
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = r_in ? (RO_MASK[r_slot] ? ro_arr[r_slot] : regs_q[r_slot]) : '0;
            rresp_d  = r_in ? 2'b00 : 2'b10;
            if (r_in) rd_pulse_d[r_slot] = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_async_rst_n) begin
        if (!i_async_rst_n) begin
            rdy_q      <= 1'b0;
            aw_held_q  <= 1'b0;
            awaddr_q   <= '0;
            w_held_q   <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= 2'b00;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= 2'b00;
            wr_pulse_q <= '0;
            rd_pulse_q <= '0;
            for (int i = 0; i < NUM_REGS; i++)
                regs_q[i] <= RO_MASK[i] ? '0 : RST_VALS[i*DW +: DW];
        end else begin
            rdy_q      <= rdy_d;
            aw_held_q  <= aw_held_d;
            awaddr_q   <= awaddr_d;
            w_held_q   <= w_held_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            wr_pulse_q <= wr_pulse_d;
            rd_pulse_q <= rd_pulse_d;
            regs_q     <= regs_d;
        end
    end
endmodule

// File: tb/tb_axi4_lite_reg_bank.sv
// tb_axi4_lite_reg_bank: directed, table-driven bench for axi4_lite_reg_bank.
module tb_axi4_lite_reg_bank;
    localparam logic [255:0] RST_VALS = {32'h0, 32'h66666666, 32'h0, 32'h0,
                                         32'h11223344, 32'hDEADBEEF, 32'h0, 32'h0};
    localparam logic [255:0] RO_VALS  = {32'h77777777, 32'h66660000, 32'hC0FFEE55, 32'h44440000,
                                         32'h33330000, 32'h22220000, 32'h11110000, 32'h00001111};

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [255:0] o_regs;
    logic [255:0] ro_vals = RO_VALS;
    logic [7:0]   wr_pulse, rd_pulse;
    int           n_tests = 0;
    int           n_fail = 0;

    axi4_lite_if #(.ADDR_W(32), .DATA_W(32)) axi ();

    axi4_lite_reg_bank #(
        .AXI4_LITE_ADDR_BIT_WIDTH(32),
        .AXI4_LITE_DATA_BIT_WIDTH(32),
        .NUM_REGS(8),
        .RO_MASK(8'h20),
        .RST_VALS(RST_VALS)
    ) dut (
        .i_clk(clk),
        .i_async_rst_n(rst_n),
        .if_s_axi4_lite(axi),
        .o_regs(o_regs),
        .i_ro_vals(ro_vals),
        .o_wr_pulse(wr_pulse),
        .o_rd_pulse(rd_pulse)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
        logic [31:0] rdata;
        logic [7:0]  pulse;
        int          slot;
        logic [31:0] slot_val;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp, output logic [7:0] pulse, output logic [7:0] pulse_after);
        bit aw_done = 0;
        bit w_done = 0;
        bit aw_f, w_f;
        int n = 0;
        axi.awaddr = a;
        axi.wdata = d;
        axi.wstrb = s;
        axi.awvalid = 1'b1;
        axi.wvalid = 1'b1;
        while (!(aw_done && w_done) && n < 20) begin
            aw_f = axi.awvalid && axi.awready;
            w_f = axi.wvalid && axi.wready;
            tick();
            n++;
            if (aw_f) begin aw_done = 1; axi.awvalid = 1'b0; end
            if (w_f) begin w_done = 1; axi.wvalid = 1'b0; end
        end
        chk("wr_handshake_done", 64'(aw_done && w_done), 64'd1);
        chk("wr_bvalid", 64'(axi.bvalid), 64'd1);
        chk("wr_readies_low", 64'({axi.awready, axi.wready}), 64'd0);
        resp = axi.bresp;
        pulse = wr_pulse;
        axi.bready = 1'b1;
        tick();
        axi.bready = 1'b0;
        pulse_after = wr_pulse;
        chk("wr_bvalid_clear", 64'(axi.bvalid), 64'd0);
        chk("wr_readies_back", 64'({axi.awready, axi.wready}), 64'd3);
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp,
                            output logic [7:0] pulse, output logic [7:0] pulse_after);
        int n = 0;
        axi.araddr = a;
        axi.arvalid = 1'b1;
        while (!axi.arready && n < 20) begin
            tick();
            n++;
        end
        chk("rd_arready_seen", 64'(axi.arready), 64'd1);
        tick();
        axi.arvalid = 1'b0;
        chk("rd_rvalid", 64'(axi.rvalid), 64'd1);
        d = axi.rdata;
        resp = axi.rresp;
        pulse = rd_pulse;
        axi.rready = 1'b1;
        tick();
        axi.rready = 1'b0;
        pulse_after = rd_pulse;
        chk("rd_rvalid_clear", 64'(axi.rvalid), 64'd0);
    endtask

    initial begin
        logic [31:0] d;
        logic [1:0]  resp;
        logic [7:0]  p, pa;
        axi.awaddr = '0; axi.awvalid = 0; axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 0;
        axi.bready = 0; axi.araddr = '0; axi.arvalid = 0; axi.rready = 0;

        vecs[0]  = '{1'b0, 32'h08, 32'h0,        4'h0, 2'b00, 32'hDEADBEEF, 8'h04, 2, 32'hDEADBEEF};
        vecs[1]  = '{1'b1, 32'h04, 32'h12345678, 4'hF, 2'b00, 32'h0,        8'h02, 1, 32'h12345678};
        vecs[2]  = '{1'b0, 32'h04, 32'h0,        4'h0, 2'b00, 32'h12345678, 8'h02, 1, 32'h12345678};
        vecs[3]  = '{1'b1, 32'h20, 32'hFFFFFFFF, 4'hF, 2'b10, 32'h0,        8'h00, 0, 32'h0};
        vecs[4]  = '{1'b1, 32'h14, 32'hFFFFFFFF, 4'hF, 2'b10, 32'h0,        8'h00, 5, 32'h0};
        vecs[5]  = '{1'b0, 32'h20, 32'h0,        4'h0, 2'b10, 32'h0,        8'h00, 0, 32'h0};
        vecs[6]  = '{1'b0, 32'h14, 32'h0,        4'h0, 2'b00, 32'hC0FFEE55, 8'h20, 5, 32'h0};
        vecs[7]  = '{1'b1, 32'h1C, 32'hA5A5A5A5, 4'h0, 2'b00, 32'h0,        8'h80, 7, 32'h0};
        vecs[8]  = '{1'b1, 32'h1E, 32'h0000BEEF, 4'h3, 2'b00, 32'h0,        8'h80, 7, 32'h0000BEEF};
        vecs[9]  = '{1'b0, 32'h1C, 32'h0,        4'h0, 2'b00, 32'h0000BEEF, 8'h80, 7, 32'h0000BEEF};
        vecs[10] = '{1'b1, 32'h00, 32'hFFFFFFFF, 4'h9, 2'b00, 32'h0,        8'h01, 0, 32'hFF0000FF};
        vecs[11] = '{1'b0, 32'h03, 32'h0,        4'h0, 2'b00, 32'hFF0000FF, 8'h01, 0, 32'hFF0000FF};
        vecs[12] = '{1'b0, 32'h10, 32'h0,        4'h0, 2'b00, 32'h0,        8'h10, 4, 32'h0};

        // reset state and first-edge ready rise
        repeat (3) tick();
        chk("rst_readies", 64'({axi.awready, axi.wready, axi.arready}), 64'd0);
        chk("rst_valids", 64'({axi.bvalid, axi.rvalid}), 64'd0);
        chk("rst_resps", 64'({axi.bresp, axi.rresp}), 64'd0);
        chk("rst_rdata", 64'(axi.rdata), 64'd0);
        chk("rst_pulses", 64'({wr_pulse, rd_pulse}), 64'd0);
        chk("rst_reg2", 64'(o_regs[2*32 +: 32]), 64'hDEADBEEF);
        rst_n = 1'b1;
        #1;
        chk("rel_readies_pre_edge", 64'({axi.awready, axi.wready, axi.arready}), 64'd0);
        tick();
        chk("rel_readies_post_edge", 64'({axi.awready, axi.wready, axi.arready}), 64'd7);

        for (int i = 0; i < 13; i++) begin
            if (vecs[i].wr) begin
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp, p, pa);
            end else begin
                axi_read(vecs[i].addr, d, resp, p, pa);
                chk($sformatf("v%0d_rdata", i), 64'(d), 64'(vecs[i].rdata));
            end
            chk($sformatf("v%0d_resp", i), 64'(resp), 64'(vecs[i].resp));
            chk($sformatf("v%0d_pulse", i), 64'(p), 64'(vecs[i].pulse));
            chk($sformatf("v%0d_pulse_after", i), 64'(pa), 64'd0);
            chk($sformatf("v%0d_slot", i), 64'(o_regs[vecs[i].slot*32 +: 32]), 64'(vecs[i].slot_val));
        end

        // W three cycles ahead of AW, partial strobes on reg3
        axi.wdata = 32'hAABBCCDD; axi.wstrb = 4'h3; axi.wvalid = 1'b1;
        tick();
        axi.wvalid = 1'b0;
        chk("wfirst_wready_low", 64'(axi.wready), 64'd0);
        tick();
        tick();
        chk("wfirst_awready", 64'(axi.awready), 64'd1);
        chk("wfirst_no_bvalid", 64'(axi.bvalid), 64'd0);
        axi.awaddr = 32'h0C; axi.awvalid = 1'b1;
        tick();
        axi.awvalid = 1'b0;
        chk("wfirst_bvalid", 64'(axi.bvalid), 64'd1);
        chk("wfirst_bresp", 64'(axi.bresp), 64'd0);
        chk("wfirst_reg3", 64'(o_regs[3*32 +: 32]), 64'h1122CCDD);
        chk("wfirst_pulse", 64'(wr_pulse), 64'h08);
        axi.bready = 1'b1;
        tick();
        axi.bready = 1'b0;
        chk("wfirst_pulse_after", 64'(wr_pulse), 64'h00);

        // same-cycle read and write of reg6, then backpressure with a second request pending
        axi.awaddr = 32'h18; axi.wdata = 32'h01020304; axi.wstrb = 4'hF; axi.araddr = 32'h18;
        axi.awvalid = 1'b1; axi.wvalid = 1'b1; axi.arvalid = 1'b1;
        tick();
        axi.awaddr = 32'h00; axi.wdata = 32'h00000BAD; axi.araddr = 32'h04;
        chk("rw_same_rdata", 64'(axi.rdata), 64'h66666666);
        chk("rw_same_reg6", 64'(o_regs[6*32 +: 32]), 64'h01020304);
        chk("rw_same_pulses", 64'({wr_pulse, rd_pulse}), 64'h4040);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk($sformatf("bp%0d_valids", c), 64'({axi.bvalid, axi.rvalid}), 64'd3);
            chk($sformatf("bp%0d_rdata", c), 64'(axi.rdata), 64'h66666666);
            chk($sformatf("bp%0d_readies", c), 64'({axi.awready, axi.wready, axi.arready}), 64'd0);
            chk($sformatf("bp%0d_reg0", c), 64'(o_regs[0 +: 32]), 64'hFF0000FF);
        end
        axi.awvalid = 1'b0; axi.wvalid = 1'b0; axi.arvalid = 1'b0;
        axi.bready = 1'b1; axi.rready = 1'b1;
        tick();
        axi.bready = 1'b0; axi.rready = 1'b0;
        chk("bp_valids_clear", 64'({axi.bvalid, axi.rvalid}), 64'd0);
        chk("bp_readies_back", 64'({axi.awready, axi.wready, axi.arready}), 64'd7);
        chk("bp_reg0_final", 64'(o_regs[0 +: 32]), 64'hFF0000FF);

        // reset after the AW half only
        axi.awaddr = 32'h04; axi.awvalid = 1'b1;
        tick();
        axi.awvalid = 1'b0;
        chk("mid_aw_held", 64'(axi.awready), 64'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_readies", 64'({axi.awready, axi.wready, axi.arready}), 64'd0);
        chk("mid_rst_bvalid", 64'(axi.bvalid), 64'd0);
        chk("mid_rst_reg1", 64'(o_regs[1*32 +: 32]), 64'h0);
        chk("mid_rst_reg6", 64'(o_regs[6*32 +: 32]), 64'h66666666);
        tick();
        rst_n = 1'b1;
        tick();
        chk("mid_rel_readies", 64'({axi.awready, axi.wready}), 64'd3);
        axi.wdata = 32'hCAFEF00D; axi.wstrb = 4'hF; axi.wvalid = 1'b1;
        tick();
        axi.wvalid = 1'b0;
        chk("mid_no_stale_commit", 64'(axi.bvalid), 64'd0);
        axi.awaddr = 32'h04; axi.awvalid = 1'b1;
        tick();
        axi.awvalid = 1'b0;
        chk("mid_after_bvalid", 64'(axi.bvalid), 64'd1);
        chk("mid_after_bresp", 64'(axi.bresp), 64'd0);
        chk("mid_after_reg1", 64'(o_regs[1*32 +: 32]), 64'hCAFEF00D);
        chk("mid_after_pulse", 64'(wr_pulse), 64'h02);
        axi.bready = 1'b1;
        tick();
        axi.bready = 1'b0;
        chk("mid_after_bclear", 64'(axi.bvalid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
